// File: rtl/rr_arb_4_1.sv
// Four-source round-robin arbiter feeding a one-word output register; 1-cycle latency.
// Backpressure: a held word with out_ready low blocks every source; drain and reload may share an edge.
module rr_arb_4_1 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [1:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q;
  logic [1:0]     ptr_q;
  logic [1:0]     sel_q;
  logic [W-1:0]   data_q;

  logic           load_ok;
  logic           grant_vld;
  logic [1:0]     grant_idx;
  logic [1:0]     scan_idx;
  logic           accept;
  logic [W-1:0]   data_d;
  logic [1:0]     ptr_d;

  assign load_ok = (state_q == EMPTY) || out_ready;

  // Scan from the farthest offset back to ptr so the nearest valid source wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (in_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign accept   = load_ok && grant_vld && !rst;
  assign in_ready = accept ? (4'b0001 << grant_idx) : 4'b0000;
  assign ptr_d    = grant_idx + 2'd1;

  always_comb begin
    data_d = d0;
    case (grant_idx)
      2'd0: data_d = d0;
      2'd1: data_d = d1;
      2'd2: data_d = d2;
      2'd3: data_d = d3;
      default: data_d = d0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
    end else if (accept) begin
      state_q <= FULL;
      ptr_q   <= ptr_d;
      sel_q   <= grant_idx;
      data_q  <= data_d;
    end else if (state_q == FULL && out_ready) begin
      state_q <= EMPTY;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

endmodule
